branch_resolve_predict: RTL and testbench

//  Parametrised successor to the branch compare-control decode. Decodes funct3 of B-type

---
 rtl/branch_resolve_predict.sv | 134 +++++++++++++
 tb/tb_branch_resolve_predict.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_predict.sv
// Branch resolution for B-type instructions with a PC-indexed BHT of saturating counters.
// Resolution, mispredict and redirect are registered; statistics counters saturate.
module branch_resolve_predict #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2,
  parameter int IDX_LSB     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic [31:0]     ex_inst,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic            ex_pred_taken,
  output logic            res_valid,
  output logic            res_taken,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic            illegal_br,
  output logic [31:0]     br_count,
  output logic [31:0]     mp_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [XLEN-1:0]     PC_STEP  = XLEN'(4);

  logic [CTR_BITS-1:0] bht_q [BHT_ENTRIES];
  logic [CTR_BITS-1:0] bht_d [BHT_ENTRIES];
  logic                res_valid_q, res_valid_d;
  logic                res_taken_q, res_taken_d;
  logic                mispredict_q, mispredict_d;
  logic                illegal_br_q, illegal_br_d;
  logic [XLEN-1:0]     redirect_pc_q, redirect_pc_d;
  logic [31:0]         br_count_q, br_count_d;
  logic [31:0]         mp_count_q, mp_count_d;

  logic [IDX_W-1:0]    if_idx, ex_idx;
  logic                is_branch, taken, illegal;
  logic                eq, lt_s, lt_u;
  logic [12:0]         imm13;
  logic [XLEN-1:0]     imm_b;
  logic [CTR_BITS-1:0] cur_ctr;
  logic                unused_bits;

  assign if_idx        = if_pc[IDX_LSB +: IDX_W];
  assign ex_idx        = ex_pc[IDX_LSB +: IDX_W];
  assign if_pred_taken = bht_q[if_idx][CTR_BITS-1];
  assign unused_bits   = ^{ex_inst[24:15], if_pc, ex_pc};

  always_comb begin
    is_branch = ex_valid && (ex_inst[6:0] == 7'b1100011);
    eq        = (ex_rs1 == ex_rs2);
    lt_s      = ($signed(ex_rs1) < $signed(ex_rs2));
    lt_u      = (ex_rs1 < ex_rs2);
    taken     = 1'b0;
    illegal   = 1'b0;
    case (ex_inst[14:12])
      3'b000:  taken = eq;
      3'b001:  taken = !eq;
      3'b100:  taken = lt_s;
      3'b101:  taken = !lt_s;
      3'b110:  taken = lt_u;
      3'b111:  taken = !lt_u;
      default: illegal = 1'b1;
    endcase
    imm13   = {ex_inst[31], ex_inst[7], ex_inst[30:25], ex_inst[11:8], 1'b0};
    imm_b   = {{(XLEN-13){imm13[12]}}, imm13};
    cur_ctr = bht_q[ex_idx];

    res_valid_d   = 1'b0;
    res_taken_d   = res_taken_q;
    mispredict_d  = mispredict_q;
    illegal_br_d  = illegal_br_q;
    redirect_pc_d = redirect_pc_q;
    br_count_d    = br_count_q;
    mp_count_d    = mp_count_q;
    bht_d         = bht_q;

    if (is_branch) begin
      res_valid_d   = 1'b1;
      res_taken_d   = taken;
      mispredict_d  = taken ^ ex_pred_taken;
      illegal_br_d  = illegal;
      redirect_pc_d = taken ? (ex_pc + imm_b) : (ex_pc + PC_STEP);
      if (br_count_q != 32'hFFFF_FFFF) br_count_d = br_count_q + 32'd1;
      if ((taken ^ ex_pred_taken) && (mp_count_q != 32'hFFFF_FFFF))
        mp_count_d = mp_count_q + 32'd1;
      // Illegal funct3 still counts but must not train the predictor.
      if (!illegal) begin
        if (taken)
          bht_d[ex_idx] = (cur_ctr == CTR_MAX) ? cur_ctr : cur_ctr + CTR_BITS'(1);
        else
          bht_d[ex_idx] = (cur_ctr == '0) ? cur_ctr : cur_ctr - CTR_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CTR_INIT;
      res_valid_q   <= 1'b0;
      res_taken_q   <= 1'b0;
      mispredict_q  <= 1'b0;
      illegal_br_q  <= 1'b0;
      redirect_pc_q <= '0;
      br_count_q    <= '0;
      mp_count_q    <= '0;
    end else begin
      bht_q         <= bht_d;
      res_valid_q   <= res_valid_d;
      res_taken_q   <= res_taken_d;
      mispredict_q  <= mispredict_d;
      illegal_br_q  <= illegal_br_d;
      redirect_pc_q <= redirect_pc_d;
      br_count_q    <= br_count_d;
      mp_count_q    <= mp_count_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_taken   = res_taken_q;
  assign mispredict  = mispredict_q;
  assign illegal_br  = illegal_br_q;
  assign redirect_pc = redirect_pc_q;
  assign br_count    = br_count_q;
  assign mp_count    = mp_count_q;

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Directed bench for branch_resolve_predict: compare decode, redirect targets,
// BHT saturation, illegal funct3, statistics saturation and reset behaviour.
module tb_branch_resolve_predict;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic [31:0] ex_inst;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic        ex_pred_taken;
  logic        res_valid;
  logic        res_taken;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        illegal_br;
  logic [31:0] br_count;
  logic [31:0] mp_count;

  int pass_count = 0;
  int fail_count = 0;
  int total_count = 0;

  branch_resolve_predict dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_pc(ex_pc),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pred_taken(ex_pred_taken),
    .res_valid(res_valid), .res_taken(res_taken), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .illegal_br(illegal_br),
    .br_count(br_count), .mp_count(mp_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] make_br(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                               input logic [31:0] a, input logic [31:0] b, input logic pred);
    ex_valid      = v;
    ex_inst       = inst;
    ex_pc         = pc;
    ex_rs1        = a;
    ex_rs2        = b;
    ex_pred_taken = pred;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkRes(input string tag, input logic v, input logic t, input logic mp,
                          input logic [31:0] rpc, input logic [31:0] bc, input logic [31:0] mc);
    checkOutput({tag, ".res_valid"}, {31'd0, res_valid}, {31'd0, v});
    checkOutput({tag, ".res_taken"}, {31'd0, res_taken}, {31'd0, t});
    checkOutput({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, mp});
    checkOutput({tag, ".redirect_pc"}, redirect_pc, rpc);
    checkOutput({tag, ".br_count"}, br_count, bc);
    checkOutput({tag, ".mp_count"}, mp_count, mc);
  endtask

  initial begin
    rst = 1'b1;
    if_pc = 32'h100;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    #1;
    checkRes("reset", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    checkOutput("reset.illegal_br", {31'd0, illegal_br}, 32'd0);
    for (int i = 0; i < 64; i++) begin
      if_pc = i << 2;
      #1;
      checkOutput("reset.bht_entry", {31'd0, if_pred_taken}, 32'd0);
    end
    tick();

    // BEQ taken, predicted not taken
    if_pc = 32'h100;
    applyStimulus(1'b1, make_br(3'b000, 13'd16), 32'h100, 32'd5, 32'd5, 1'b0);
    tick();
    checkRes("beq", 1'b1, 1'b1, 1'b1, 32'h110, 32'd1, 32'd1);
    checkOutput("beq.if_pred", {31'd0, if_pred_taken}, 32'd1);
    ex_valid = 1'b0;
    tick();
    checkRes("idle_hold", 1'b0, 1'b1, 1'b1, 32'h110, 32'd1, 32'd1);

    // Compare variants, back-to-back
    applyStimulus(1'b1, make_br(3'b100, 13'h1FF8), 32'h204, 32'hFFFF_FFFF, 32'd1, 1'b1);
    tick();
    checkRes("blt", 1'b1, 1'b1, 1'b0, 32'h1FC, 32'd2, 32'd1);
    applyStimulus(1'b1, make_br(3'b110, 13'd32), 32'h208, 32'hFFFF_FFFF, 32'd1, 1'b0);
    tick();
    checkRes("bltu", 1'b1, 1'b0, 1'b0, 32'h20C, 32'd3, 32'd1);
    applyStimulus(1'b1, make_br(3'b101, 13'd8), 32'h20C, 32'd7, 32'd7, 1'b1);
    tick();
    checkRes("bge_eq", 1'b1, 1'b1, 1'b0, 32'h214, 32'd4, 32'd1);
    applyStimulus(1'b1, make_br(3'b111, 13'd4), 32'h210, 32'd7, 32'd7, 1'b1);
    tick();
    checkRes("bgeu_eq", 1'b1, 1'b1, 1'b0, 32'h214, 32'd5, 32'd1);
    applyStimulus(1'b1, make_br(3'b001, 13'd64), 32'h214, 32'd3, 32'd3, 1'b0);
    tick();
    checkRes("bne_eq", 1'b1, 1'b0, 1'b0, 32'h218, 32'd6, 32'd1);
    applyStimulus(1'b1, make_br(3'b000, 13'd8), 32'hFFFF_FFFC, 32'd9, 32'd9, 1'b1);
    tick();
    checkRes("pc_wrap", 1'b1, 1'b1, 1'b0, 32'h4, 32'd7, 32'd1);

    // Counter saturation on one index; same-cycle lookup shows the pre-update value
    if_pc = 32'h0C0;
    applyStimulus(1'b1, make_br(3'b000, 13'd8), 32'h0C0, 32'd1, 32'd1, 1'b1);
    #1;
    checkOutput("no_bypass", {31'd0, if_pred_taken}, 32'd0);
    tick();
    checkOutput("sat.t1", {31'd0, if_pred_taken}, 32'd1);
    tick();
    checkOutput("sat.t2", {31'd0, if_pred_taken}, 32'd1);
    tick();
    checkOutput("sat.t3", {31'd0, if_pred_taken}, 32'd1);
    tick();
    checkOutput("sat.t4", {31'd0, if_pred_taken}, 32'd1);
    applyStimulus(1'b1, make_br(3'b001, 13'd8), 32'h0C0, 32'd1, 32'd1, 1'b0);
    tick();
    checkOutput("sat.n1", {31'd0, if_pred_taken}, 32'd1);
    tick();
    checkOutput("sat.n2", {31'd0, if_pred_taken}, 32'd0);
    tick();
    checkOutput("sat.n3", {31'd0, if_pred_taken}, 32'd0);
    tick();
    checkOutput("sat.n4", {31'd0, if_pred_taken}, 32'd0);
    applyStimulus(1'b1, make_br(3'b000, 13'd8), 32'h0C0, 32'd1, 32'd1, 1'b1);
    tick();
    checkOutput("sat.up_from_zero", {31'd0, if_pred_taken}, 32'd0);
    checkOutput("sat.br_count", br_count, 32'd16);
    checkOutput("sat.mp_count", mp_count, 32'd1);

    // Illegal funct3 on an index holding 10: must not train it
    if_pc = 32'h204;
    applyStimulus(1'b1, make_br(3'b010, 13'd16), 32'h204, 32'd1, 32'd1, 1'b1);
    tick();
    checkRes("illegal010", 1'b1, 1'b0, 1'b1, 32'h208, 32'd17, 32'd2);
    checkOutput("illegal010.flag", {31'd0, illegal_br}, 32'd1);
    checkOutput("illegal010.bht", {31'd0, if_pred_taken}, 32'd1);
    applyStimulus(1'b1, make_br(3'b011, 13'd16), 32'h204, 32'd1, 32'd2, 1'b0);
    tick();
    checkRes("illegal011", 1'b1, 1'b0, 1'b0, 32'h208, 32'd18, 32'd2);
    checkOutput("illegal011.flag", {31'd0, illegal_br}, 32'd1);
    checkOutput("illegal011.bht", {31'd0, if_pred_taken}, 32'd1);

    // Non-branch opcode, and a branch without ex_valid
    applyStimulus(1'b1, 32'h0020_80B3, 32'h204, 32'd1, 32'd2, 1'b1);
    tick();
    checkRes("nonbranch", 1'b0, 1'b0, 1'b0, 32'h208, 32'd18, 32'd2);
    checkOutput("nonbranch.flag", {31'd0, illegal_br}, 32'd1);
    applyStimulus(1'b0, make_br(3'b000, 13'd16), 32'h204, 32'd1, 32'd2, 1'b1);
    tick();
    checkRes("invalid", 1'b0, 1'b0, 1'b0, 32'h208, 32'd18, 32'd2);
    checkOutput("invalid.bht", {31'd0, if_pred_taken}, 32'd1);

    // Statistics saturation
    force dut.br_count_q = 32'hFFFF_FFFF;
    force dut.mp_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.br_count_q;
    release dut.mp_count_q;
    applyStimulus(1'b1, make_br(3'b000, 13'd16), 32'h100, 32'd5, 32'd5, 1'b0);
    tick();
    checkOutput("stat_sat.br_count", br_count, 32'hFFFF_FFFF);
    checkOutput("stat_sat.mp_count", mp_count, 32'hFFFF_FFFF);

    // Branch in EX during reset is discarded
    rst = 1'b1;
    applyStimulus(1'b1, make_br(3'b000, 13'd16), 32'h204, 32'd5, 32'd5, 1'b0);
    tick();
    rst = 1'b0;
    ex_valid = 1'b0;
    checkRes("rst_branch", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    checkOutput("rst_branch.illegal", {31'd0, illegal_br}, 32'd0);
    if_pc = 32'h0C0;
    #1;
    checkOutput("rst_branch.bht", {31'd0, if_pred_taken}, 32'd0);
    tick();
    applyStimulus(1'b1, make_br(3'b001, 13'd16), 32'h100, 32'd5, 32'd6, 1'b1);
    tick();
    checkRes("post_rst", 1'b1, 1'b1, 1'b0, 32'h110, 32'd1, 32'd0);
    ex_valid = 1'b0;

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
